// File: rtl/datapath_pipe_alu.sv
// Two-stage register-file/ALU datapath (R: operand read + forwarding, E: execute/writeback); op at edge n shows on result after edge n.
// stall=1 freezes pipeline, register file and status; in-flight op commits once on the first unstalled edge.
module datapath_pipe_alu #(
   parameter int WIDTH = 64,
   parameter int REGS  = 32,
   localparam int AW   = $clog2(REGS)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             stall,
   input  logic [AW-1:0]    DA,
   input  logic [AW-1:0]    SA,
   input  logic [AW-1:0]    SB,
   input  logic [4:0]       FS,
   input  logic [WIDTH-1:0] K,
   input  logic             selB,
   input  logic             regW,
   input  logic             SL,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [4:0]       status_out
);

   localparam int            SW       = $clog2(WIDTH);
   localparam logic [AW-1:0] ZERO_REG = AW'(REGS - 1);

   localparam logic [4:0] FS_AND  = 5'd0;
   localparam logic [4:0] FS_OR   = 5'd1;
   localparam logic [4:0] FS_XOR  = 5'd2;
   localparam logic [4:0] FS_ADD  = 5'd3;
   localparam logic [4:0] FS_SUB  = 5'd4;
   localparam logic [4:0] FS_SHL  = 5'd5;
   localparam logic [4:0] FS_SHR  = 5'd6;
   localparam logic [4:0] FS_PASS = 5'd7;

   typedef struct packed {
      logic             vld;
      logic             reg_w;
      logic             sl;
      logic [AW-1:0]    da;
      logic [4:0]       fs;
      logic [WIDTH-1:0] a_dat;
      logic [WIDTH-1:0] b_dat;
   } e_stage_t;

   logic [WIDTH-1:0] rf [REGS];
   e_stage_t         e_q;
   e_stage_t         r_dat;
   logic [WIDTH-1:0] fwd_a;
   logic [WIDTH-1:0] fwd_b;
   logic [3:0]       status_q;

   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   dif_ext;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic             alu_z;
   logic             alu_n;
   logic             wb_en;
   logic             sl_en;

   // R stage: the E-stage op is the only hazard source; the zero register overrides everything
   always_comb begin
      fwd_a = rf[SA];
      if (e_q.vld && e_q.reg_w && (e_q.da == SA)) fwd_a = result;
      if (SA == ZERO_REG) fwd_a = '0;

      fwd_b = rf[SB];
      if (e_q.vld && e_q.reg_w && (e_q.da == SB)) fwd_b = result;
      if (SB == ZERO_REG) fwd_b = '0;
   end

   always_comb begin
      r_dat       = '0;
      r_dat.vld   = in_valid;
      r_dat.reg_w = regW;
      r_dat.sl    = SL;
      r_dat.da    = DA;
      r_dat.fs    = FS;
      r_dat.a_dat = fwd_a;
      r_dat.b_dat = selB ? K : fwd_b;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         e_q <= '0;
      end else if (!stall) begin
         e_q <= r_dat;
      end
   end

   // A + ~B + 1: carry out is set exactly when there is no borrow (A >= B unsigned)
   assign sum_ext = {1'b0, e_q.a_dat} + {1'b0, e_q.b_dat};
   assign dif_ext = {1'b0, e_q.a_dat} + {1'b0, ~e_q.b_dat} + (WIDTH+1)'(1);

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (e_q.fs)
         FS_AND:  alu_res = e_q.a_dat & e_q.b_dat;
         FS_OR:   alu_res = e_q.a_dat | e_q.b_dat;
         FS_XOR:  alu_res = e_q.a_dat ^ e_q.b_dat;
         FS_ADD: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (e_q.a_dat[WIDTH-1] == e_q.b_dat[WIDTH-1]) &&
                      (sum_ext[WIDTH-1] != e_q.a_dat[WIDTH-1]);
         end
         FS_SUB: begin
            alu_res = dif_ext[WIDTH-1:0];
            alu_c   = dif_ext[WIDTH];
            alu_v   = (e_q.a_dat[WIDTH-1] != e_q.b_dat[WIDTH-1]) &&
                      (dif_ext[WIDTH-1] != e_q.a_dat[WIDTH-1]);
         end
         FS_SHL:  alu_res = e_q.a_dat << e_q.b_dat[SW-1:0];
         FS_SHR:  alu_res = e_q.a_dat >> e_q.b_dat[SW-1:0];
         FS_PASS: alu_res = e_q.b_dat;
         default: alu_res = '0;
      endcase
      alu_n = alu_res[WIDTH-1];
      alu_z = (alu_res == '0);
   end

   assign wb_en = !stall && e_q.vld && e_q.reg_w && (e_q.da != ZERO_REG);
   assign sl_en = !stall && e_q.vld && e_q.sl;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REGS; i++) rf[i] <= '0;
      end else if (wb_en) begin
         rf[e_q.da] <= alu_res;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         status_q <= '0;
      end else if (sl_en) begin
         status_q <= {alu_v, alu_c, alu_z, alu_n};
      end
   end

   assign out_valid = e_q.vld;
   assign result    = alu_res;
   // Live Z is masked while reset is held so every output reads zero during reset
   assign status_out = {status_q, alu_z & ~reset};

endmodule

// File: tb/tb_datapath_pipe_alu.sv
// Directed bench for datapath_pipe_alu with hand-computed expectations.
module tb_datapath_pipe_alu;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        stall;
   logic [4:0]  DA;
   logic [4:0]  SA;
   logic [4:0]  SB;
   logic [4:0]  FS;
   logic [63:0] K;
   logic        selB;
   logic        regW;
   logic        SL;
   logic        out_valid;
   logic [63:0] result;
   logic [4:0]  status_out;

   int errors = 0;
   int checks = 0;

   datapath_pipe_alu #(.WIDTH(64), .REGS(32)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .stall      (stall),
      .DA         (DA),
      .SA         (SA),
      .SB         (SB),
      .FS         (FS),
      .K          (K),
      .selB       (selB),
      .regW       (regW),
      .SL         (SL),
      .out_valid  (out_valid),
      .result     (result),
      .status_out (status_out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic v, input logic [4:0] da, input logic [4:0] sa,
                        input logic [4:0] sb, input logic [4:0] fs, input logic [63:0] k,
                        input logic selb, input logic regw, input logic sl);
      in_valid = v;
      DA       = da;
      SA       = sa;
      SB       = sb;
      FS       = fs;
      K        = k;
      selB     = selb;
      regW     = regw;
      SL       = sl;
      @(posedge clock);
      #1;
   endtask

   task automatic rd(input logic [4:0] r);
      issue(1'b1, 5'd0, 5'd31, r, 5'd7, 64'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      stall = 1'b0;
      in_valid = 1'b0; DA = '0; SA = '0; SB = '0; FS = '0; K = '0;
      selB = 1'b0; regW = 1'b0; SL = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_status", status_out, 5'b00000);

      reset = 1'b0;
      @(posedge clock);
      #1;
      chk("idle_out_valid", out_valid, 0);
      chk("idle_live_z", status_out, 5'b00001);

      // forwarding: reg1 = 0 + 5, then reg2 = reg1 + reg1 with no bubble
      issue(1, 5'd1, 5'd31, 5'd0, 5'd3, 64'd5, 1, 1, 0);
      chk("fwd_res0", result, 64'd5);
      chk("fwd_valid0", out_valid, 1);
      issue(1, 5'd2, 5'd1, 5'd1, 5'd3, 64'd0, 0, 1, 0);
      chk("fwd_res1", result, 64'd10);
      rd(5'd1);
      chk("reg1_wb", result, 64'd5);
      rd(5'd2);
      chk("reg2_wb", result, 64'd10);

      // SUB 5-10 with status load
      issue(1, 5'd0, 5'd1, 5'd2, 5'd4, 64'd0, 0, 0, 1);
      chk("sub_res", result, 64'hFFFF_FFFF_FFFF_FFFB);
      chk("sub_status_pre", status_out, 5'b00000);
      rd(5'd1);
      chk("sub_status", status_out, 5'b00010);

      // ADD signed overflow
      issue(1, 5'd1, 5'd31, 5'd0, 5'd7, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0);
      chk("ovf_load", result, 64'h7FFF_FFFF_FFFF_FFFF);
      issue(1, 5'd0, 5'd1, 5'd0, 5'd3, 64'd1, 1, 0, 1);
      chk("ovf_res", result, 64'h8000_0000_0000_0000);
      issue(1, 5'd0, 5'd31, 5'd0, 5'd7, 64'd1, 1, 0, 0);
      chk("ovf_status", status_out, 5'b10010);

      // SUB with no borrow (10-10): Z and C set; live Z also visible
      issue(1, 5'd0, 5'd2, 5'd0, 5'd4, 64'd10, 1, 0, 1);
      chk("subz_res", result, 64'd0);
      chk("subz_live", status_out, 5'b10011);
      issue(1, 5'd0, 5'd31, 5'd0, 5'd7, 64'd1, 1, 0, 0);
      chk("subz_status", status_out, 5'b01100);

      // ADD carry out without overflow: 10 + (-1)
      issue(1, 5'd0, 5'd2, 5'd0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1);
      chk("addc_res", result, 64'd9);
      issue(1, 5'd0, 5'd31, 5'd0, 5'd7, 64'd1, 1, 0, 0);
      chk("addc_status", status_out, 5'b01000);

      // logic/shift ops on reg2 = 0xA with immediate B
      issue(1, 5'd0, 5'd2, 5'd0, 5'd0, 64'd6, 1, 0, 0);
      chk("and", result, 64'h2);
      issue(1, 5'd0, 5'd2, 5'd0, 5'd1, 64'd6, 1, 0, 0);
      chk("or", result, 64'hE);
      issue(1, 5'd0, 5'd2, 5'd0, 5'd2, 64'd6, 1, 0, 0);
      chk("xor", result, 64'hC);
      issue(1, 5'd0, 5'd2, 5'd0, 5'd5, 64'h44, 1, 0, 0);
      chk("shl_masked", result, 64'hA0);
      issue(1, 5'd0, 5'd2, 5'd0, 5'd6, 64'h41, 1, 0, 0);
      chk("shr_masked", result, 64'h5);
      issue(1, 5'd0, 5'd2, 5'd0, 5'd8, 64'd6, 1, 0, 0);
      chk("fs8_zero", result, 64'd0);
      issue(1, 5'd0, 5'd2, 5'd0, 5'd31, 64'd6, 1, 0, 0);
      chk("fs31_zero", result, 64'd0);

      // zero register: writes discarded, no forwarding from it
      issue(1, 5'd31, 5'd31, 5'd0, 5'd7, 64'hAB, 1, 1, 0);
      chk("zr_write_res", result, 64'hAB);
      issue(1, 5'd0, 5'd31, 5'd31, 5'd7, 64'd0, 0, 0, 0);
      chk("zr_no_fwd", result, 64'd0);
      rd(5'd31);
      chk("zr_read", result, 64'd0);

      // stall: reg3 = 7, then reg3 = reg3 + 1 held for three cycles
      issue(1, 5'd3, 5'd31, 5'd0, 5'd7, 64'd7, 1, 1, 0);
      chk("stall_set", result, 64'd7);
      issue(1, 5'd3, 5'd3, 5'd0, 5'd3, 64'd1, 1, 1, 1);
      chk("stall_add", result, 64'd8);
      stall = 1'b1;
      in_valid = 1'b1; DA = 5'd3; SA = 5'd3; FS = 5'd7; K = 64'h99;
      selB = 1'b1; regW = 1'b1; SL = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         chk("stall_result", result, 64'd8);
         chk("stall_valid", out_valid, 1);
         chk("stall_status", status_out, 5'b01000);
      end
      stall = 1'b0;
      rd(5'd3);
      chk("release_fwd", result, 64'd8);
      chk("release_status", status_out, 5'b00000);
      rd(5'd3);
      chk("reg3_once", result, 64'd8);

      // asynchronous reset mid-operation discards in-flight writeback
      issue(1, 5'd4, 5'd31, 5'd0, 5'd7, 64'h55, 1, 1, 0);
      chk("pre_rst_res", result, 64'h55);
      chk("pre_rst_valid", out_valid, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_result", result, 0);
      chk("midrst_status", status_out, 5'b00000);
      in_valid = 1'b0; regW = 1'b0; SL = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      rd(5'd4);
      chk("post_rst_reg4", result, 64'd0);
      rd(5'd1);
      chk("post_rst_reg1", result, 64'd0);
      rd(5'd2);
      chk("post_rst_reg2", result, 64'd0);
      rd(5'd3);
      chk("post_rst_reg3", result, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/datapath_pipe_alu.md
Name: datapath_pipe_alu

Overview:
Parametrised next-generation register-file/ALU datapath with a two-stage pipeline: operand read (R) and execute/writeback (E). Adds configurable width and register count, a hardwired zero register, E-to-R forwarding, a stall input and a valid flag. Flag semantics match the existing datapath, with the status register loaded on SL. It sits between the control unit (which supplies decoded fields plus K) and memory/PC logic, which consume result.

Parameters:
WIDTH, 64, datapath/register width in bits (power of two, >=8)
REGS, 32, number of registers (power of two); register REGS-1 is the zero register
AW, log2(REGS), register address width (derived, not overridden)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  R-stage fields valid this cycle
stall  input  1  freeze all pipeline, register-file and status state
DA  input  AW  destination register
SA  input  AW  source A register
SB  input  AW  source B register
FS  input  5  ALU function select
K  input  WIDTH  immediate
selB  input  1  1: B operand = K; 0: B operand = reg[SB]
regW  input  1  write result to DA
SL  input  1  load status register from this op's flags
out_valid  output  1  E stage holds a valid op
result  output  WIDTH  E-stage ALU result (combinational from E registers)
status_out  output  5  {statusReg[3:0] = V,C,Z,N, live Z of result}

Behaviour:
- Reset (async, any time, including mid-operation): all registers = 0; E-stage registers cleared (valid=0, FS=0, operands=0); statusReg = 0. Outputs: out_valid=0, result=0, status_out=0. Any in-flight op is discarded with no writeback.
- R stage, combinational:
  - A = fwd(SA). B = selB ? K : fwd(SB).
  - fwd(r) = 0 if r==REGS-1.
  - Otherwise fwd(r) = result if E.valid & E.regW & E.DA==r.
  - Otherwise fwd(r) = reg[r].
- Rising edge with stall=0:
  - E.valid <= in_valid.
  - E.{DA,FS,A,B,regW,SL} <= R values.
- E stage:
  - out_valid = E.valid.
  - result = ALU(E.A, E.B, E.FS).
- Writeback, on an edge with stall=0 and E.valid & E.regW: reg[E.DA] <= result, unless E.DA==REGS-1 (discarded).
- Status load, on an edge with stall=0 and E.valid & E.SL: statusReg <= {V,C,Z,N}.
- stall=1: every register holds; result and status_out stay stable. Writeback and status load each occur exactly once per op.
- Latency: op presented at edge n appears on result after edge n. It commits to the register file and status at edge n+1, or at the first later unstalled edge.
- ALU FS codes:
  - 0 AND, 1 OR, 2 XOR, 3 ADD (A+B), 4 SUB (A-B), 5 SHL, 6 SHR logical, 7 PASS B.
  - Any other code yields result = 0.
  - Shift amount = B[log2(WIDTH)-1:0].
  - Arithmetic is modulo 2^WIDTH.
- Flags:
  - N = result[WIDTH-1].
  - Z = (result==0).
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = 1 when no borrow (A>=B unsigned); V = signed overflow of A-B.
  - All other ops: C = V = 0.
- status_out[0] = live Z of result even when out_valid=0, matching the existing datapath.
- Back-to-back dependent ops need no bubbles. Only one E stage exists, so no older hazard source exists.

Test Plan:
- Reset: assert reset mid-run with E.valid=1 and regW=1 -> out_valid=0, result=0, status_out=0; target register not written; all registers read 0 afterwards.
- Forwarding: cycle0: DA=1, SA=31, K=5, selB=1, FS=3. Cycle1: DA=2, SA=1, SB=1, selB=0, FS=3 -> result=5 then 10; reg1=5, reg2=10; no stall cycles.
- Flags on SUB: reg1=5, reg2=10; FS=4, SA=1, SB=2, SL=1 -> result=0xFFFF_FFFF_FFFF_FFFB; statusReg {V,C,Z,N}=0001; status_out=5'b00010.
- Overflow on ADD: reg1=0x7FFF_FFFF_FFFF_FFFF, K=1, selB=1, FS=3, SL=1 -> result=0x8000_0000_0000_0000; statusReg=1001.
- Zero register: DA=31, K=0xAB, FS=7, regW=1; next op reads SA=31 with FS=7, selB=0, SB=31 -> result=0; reg31 stays 0.
- Stall: ADD reg3=reg3+1 issued, then stall=1 for 3 cycles -> result, out_valid and status_out unchanged; reg3 increments by exactly 1 after release.
